alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width (even, >= 4).
REQ-002 Parameter: OPW, default 4, width of ALU_op_i.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 ALU_valid_i  input  1  request strobe; sampled only when ALU_busy_o=0.
REQ-006 ALU_op_i  input  OPW  operation code (REQ-011).
REQ-007 ALU_data1_i  input  XLEN  operand A.
REQ-008 ALU_data2_i  input  XLEN  operand B.
REQ-009 ALU_result_o  output  XLEN  registered result; holds until the next completion.
REQ-010 ALU_valid_o  output  1  one-cycle completion pulse; ALU_busy_o  output  1  multi-cycle op in progress.

Function
REQ-011 Op codes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
- 5 SLL, 6 SRL, 7 SRA: shift amount = ALU_data2_i[log2(XLEN)-1:0]
- 8 SLT (signed), 9 SLTU: result 1 or 0, zero-extended
- 10 MUL (low XLEN bits), 11 MULHU (high XLEN bits, unsigned)
- 12 DIVU, 13 REMU
- 14-15 undefined: result 0, single-cycle.
REQ-012 Accept: ALU_valid_i=1 and ALU_busy_o=0 in a cycle; operands and op captured that edge.
REQ-013 Single-cycle ops (0-9, 14-15): ALU_valid_o=1 and ALU_result_o updated in cycle after accept; ALU_busy_o stays 0; back-to-back accepts every cycle.
REQ-014 Add/sub wrap modulo 2^XLEN; no carry/overflow output.
REQ-015 Multi-cycle ops (10-13): FSM states IDLE -> MUL or DIV -> DONE -> IDLE.
REQ-016 MUL: radix-2 shift-add, one bit per cycle, XLEN iteration cycles; full 2*XLEN product held internally.
REQ-017 DIV: restoring unsigned division, one quotient bit per cycle, XLEN iteration cycles.
REQ-018 ALU_busy_o=1 exactly in MUL/DIV states, i.e. cycles T+1..T+XLEN for accept at cycle T.
REQ-019 DONE at cycle T+XLEN+1: ALU_valid_o=1, ALU_result_o valid, ALU_busy_o=0; a new request can be accepted in DONE.
REQ-020 ALU_valid_i while ALU_busy_o=1: ignored; no queuing, no effect on the running op.
REQ-021 Divide by zero: DIVU gives all ones; REMU gives ALU_data1_i. Still takes full XLEN-cycle latency.
REQ-022 Operand inputs changing after accept do not affect the running op.
REQ-023 ALU_result_o changes only in a ALU_valid_o=1 cycle.

Reset
REQ-024 rst_n=0 at a rising edge: FSM -> IDLE, iteration counter cleared, ALU_result_o=0, ALU_valid_o=0, ALU_busy_o=0.
REQ-025 Reset mid multi-cycle op: op aborted, no ALU_valid_o pulse afterwards.
REQ-026 Reset coincident with ALU_valid_i=1: request dropped.

Verification
REQ-027 XLEN=32, ADD 0xFFFFFFFF+0x00000001 -> next cycle ALU_valid_o=1, result 0x00000000, ALU_busy_o=0.
REQ-028 SRA 0x80000000 by 4 -> 0xF8000000; SLT 0xFFFFFFFF vs 0x1 -> 1; SLTU same operands -> 0.
REQ-029 MULHU 0xFFFFFFFF*0xFFFFFFFF, accept cycle T -> busy T+1..T+32, valid at T+33, result 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-030 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-031 ALU_valid_i held high with ADD during a DIVU -> ignored; a new op accepted in the DONE cycle completes one cycle later.
REQ-032 rst_n=0 at cycle T+10 of a MUL -> all outputs 0 next cycle, no valid pulse afterwards; a subsequent ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift/compare ops plus an
// iterative shift-add multiplier and restoring unsigned divider.
module alu_mc #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ALU_valid_i,
    input  logic [OPW-1:0]  ALU_op_i,
    input  logic [XLEN-1:0] ALU_data1_i,
    input  logic [XLEN-1:0] ALU_data2_i,
    output logic [XLEN-1:0] ALU_result_o,
    output logic            ALU_valid_o,
    output logic            ALU_busy_o
);
    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = $clog2(XLEN);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
    localparam logic [OPW-1:0] OP_AND   = OPW'(2);
    localparam logic [OPW-1:0] OP_OR    = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL   = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL   = OPW'(6);
    localparam logic [OPW-1:0] OP_SRA   = OPW'(7);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(8);
    localparam logic [OPW-1:0] OP_SLTU  = OPW'(9);
    localparam logic [OPW-1:0] OP_MUL   = OPW'(10);
    localparam logic [OPW-1:0] OP_MULHU = OPW'(11);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(12);
    localparam logic [OPW-1:0] OP_REMU  = OPW'(13);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e            state_r,  state_nxt_s;
    logic [CNTW-1:0]   cnt_r,    cnt_nxt_s;
    logic [OPW-1:0]    op_r,     op_nxt_s;
    logic [XLEN-1:0]   opnd_r,   opnd_nxt_s;
    logic [XLEN-1:0]   hi_r,     hi_nxt_s;
    logic [XLEN-1:0]   lo_r,     lo_nxt_s;
    logic [XLEN-1:0]   result_r, result_nxt_s;
    logic              valid_r,  valid_nxt_s;
    logic              busy_r,   busy_nxt_s;

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN-1:0]   mul_hi_s, mul_lo_s;
    logic [XLEN:0]     div_shift_s, div_diff_s;
    logic [XLEN-1:0]   div_hi_s, div_lo_s;
    logic              last_s, is_mul_s, is_div_s;

    function automatic logic [XLEN-1:0] single_op(
        input logic [OPW-1:0]  op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  single_op = a + b;
            OP_SUB:  single_op = a - b;
            OP_AND:  single_op = a & b;
            OP_OR:   single_op = a | b;
            OP_XOR:  single_op = a ^ b;
            OP_SLL:  single_op = a << sh;
            OP_SRL:  single_op = a >> sh;
            OP_SRA:  single_op = $unsigned($signed(a) >>> sh);
            OP_SLT:  single_op = ($signed(a) < $signed(b)) ? XLEN'(1) : {XLEN{1'b0}};
            OP_SLTU: single_op = (a < b) ? XLEN'(1) : {XLEN{1'b0}};
            default: single_op = {XLEN{1'b0}};
        endcase
    endfunction

    // Iteration datapath: hi/lo hold the running product, or remainder/quotient.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        mul_hi_s    = mul_sum_s[XLEN:1];
        mul_lo_s    = {mul_sum_s[0], lo_r[XLEN-1:1]};
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        div_hi_s    = div_diff_s[XLEN] ? div_shift_s[XLEN-1:0] : div_diff_s[XLEN-1:0];
        div_lo_s    = {lo_r[XLEN-2:0], ~div_diff_s[XLEN]};
        last_s      = (cnt_r == CNTW'(XLEN-1));
        is_mul_s    = (ALU_op_i == OP_MUL)  || (ALU_op_i == OP_MULHU);
        is_div_s    = (ALU_op_i == OP_DIVU) || (ALU_op_i == OP_REMU);
    end

    // Next-state and next-output logic; DONE accepts like IDLE.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        op_nxt_s     = op_r;
        opnd_nxt_s   = opnd_r;
        hi_nxt_s     = hi_r;
        lo_nxt_s     = lo_r;
        result_nxt_s = result_r;
        valid_nxt_s  = 1'b0;
        busy_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                state_nxt_s = ST_IDLE;
                if (ALU_valid_i) begin
                    if (is_mul_s || is_div_s) begin
                        state_nxt_s = is_mul_s ? ST_MUL : ST_DIV;
                        busy_nxt_s  = 1'b1;
                        cnt_nxt_s   = {CNTW{1'b0}};
                        op_nxt_s    = ALU_op_i;
                        hi_nxt_s    = {XLEN{1'b0}};
                        lo_nxt_s    = is_mul_s ? ALU_data2_i : ALU_data1_i;
                        opnd_nxt_s  = is_mul_s ? ALU_data1_i : ALU_data2_i;
                    end else begin
                        result_nxt_s = single_op(ALU_op_i, ALU_data1_i, ALU_data2_i);
                        valid_nxt_s  = 1'b1;
                    end
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            ST_MUL: begin
                hi_nxt_s = mul_hi_s;
                lo_nxt_s = mul_lo_s;
                if (last_s) begin
                    state_nxt_s  = ST_DONE;
                    valid_nxt_s  = 1'b1;
                    cnt_nxt_s    = {CNTW{1'b0}};
                    result_nxt_s = (op_r == OP_MULHU) ? mul_hi_s : mul_lo_s;
                end else begin
                    busy_nxt_s = 1'b1;
                    cnt_nxt_s  = cnt_r + CNTW'(1);
                end
            end
            ST_DIV: begin
                hi_nxt_s = div_hi_s;
                lo_nxt_s = div_lo_s;
                if (last_s) begin
                    state_nxt_s  = ST_DONE;
                    valid_nxt_s  = 1'b1;
                    cnt_nxt_s    = {CNTW{1'b0}};
                    result_nxt_s = (op_r == OP_REMU) ? div_hi_s : div_lo_s;
                end else begin
                    busy_nxt_s = 1'b1;
                    cnt_nxt_s  = cnt_r + CNTW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNTW{1'b0}};
            op_r     <= {OPW{1'b0}};
            opnd_r   <= {XLEN{1'b0}};
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            result_r <= {XLEN{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            op_r     <= op_nxt_s;
            opnd_r   <= opnd_nxt_s;
            hi_r     <= hi_nxt_s;
            lo_r     <= lo_nxt_s;
            result_r <= result_nxt_s;
            valid_r  <= valid_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign ALU_result_o = result_r;
    assign ALU_valid_o  = valid_r;
    assign ALU_busy_o   = busy_r;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: cycle model with plain-arithmetic results,
// per-cycle compare process, and hand-computed literal expectations.
module tb_alu_mc;
    localparam int XLEN = 32;
    localparam int OPW  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ALU_valid_i;
    logic [OPW-1:0]    ALU_op_i;
    logic [XLEN-1:0]   ALU_data1_i;
    logic [XLEN-1:0]   ALU_data2_i;
    logic [XLEN-1:0]   ALU_result_o;
    logic              ALU_valid_o;
    logic              ALU_busy_o;

    int errors = 0;
    int checks = 0;

    logic              exp_valid = 1'b0;
    logic              exp_busy  = 1'b0;
    logic [XLEN-1:0]   exp_res   = '0;
    logic [XLEN-1:0]   m_pend    = '0;
    int                m_busy_left = 0;
    bit                chk_en = 1'b0;

    alu_mc #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ALU_valid_i  (ALU_valid_i),
        .ALU_op_i     (ALU_op_i),
        .ALU_data1_i  (ALU_data1_i),
        .ALU_data2_i  (ALU_data2_i),
        .ALU_result_o (ALU_result_o),
        .ALU_valid_o  (ALU_valid_o),
        .ALU_busy_o   (ALU_busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[4:0];
            4'd6:  return a >> b[4:0];
            4'd7:  return $unsigned($signed(a) >>> b[4:0]);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        if (!rst_n) begin
            exp_valid = 1'b0; exp_busy = 1'b0; exp_res = '0; m_busy_left = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                exp_valid = 1'b1; exp_busy = 1'b0; exp_res = m_pend;
            end else begin
                exp_valid = 1'b0; exp_busy = 1'b1;
            end
        end else begin
            exp_valid = 1'b0; exp_busy = 1'b0;
            if (ALU_valid_i) begin
                if (ALU_op_i >= 4'd10 && ALU_op_i <= 4'd13) begin
                    m_pend = ref_result(ALU_op_i, ALU_data1_i, ALU_data2_i);
                    m_busy_left = XLEN;
                    exp_busy = 1'b1;
                end else begin
                    exp_res = ref_result(ALU_op_i, ALU_data1_i, ALU_data2_i);
                    exp_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_o", {31'd0, ALU_valid_o}, {31'd0, exp_valid});
            check("busy_o", {31'd0, ALU_busy_o}, {31'd0, exp_busy});
            check("result_o", ALU_result_o, exp_res);
        end
    end

    task automatic single(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        ALU_valid_i = 1'b1; ALU_op_i = o; ALU_data1_i = a; ALU_data2_i = b;
        tick();
        check({name, "_res"}, ALU_result_o, exp);
        check({name, "_vld"}, {31'd0, ALU_valid_o}, 32'd1);
    endtask

    task automatic multi(input string name, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int n;
        ALU_valid_i = 1'b1; ALU_op_i = o; ALU_data1_i = a; ALU_data2_i = b;
        tick();
        ALU_valid_i = 1'b0;
        n = 1;
        while (!ALU_valid_o && n < 100) begin
            tick();
            n++;
        end
        check({name, "_lat"}, n, XLEN + 1);
        check({name, "_res"}, ALU_result_o, exp);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; ALU_valid_i = 1'b0; ALU_op_i = '0; ALU_data1_i = '0; ALU_data2_i = '0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_res", ALU_result_o, 32'd0);
        check("rst_vld", {31'd0, ALU_valid_o}, 32'd0);
        check("rst_busy", {31'd0, ALU_busy_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back single-cycle ops.
        single("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        check("add_busy", {31'd0, ALU_busy_o}, 32'd0);
        single("sub",      4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE);
        single("and",      4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        single("or",       4'd3,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0);
        single("xor",      4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        single("sll_mask", 4'd5,  32'd1,         32'h0000_0021, 32'h0000_0002);
        single("sll31",    4'd5,  32'd1,         32'd31,        32'h8000_0000);
        single("srl",      4'd6,  32'h8000_0000, 32'd4,         32'h0800_0000);
        single("sra",      4'd7,  32'h8000_0000, 32'd4,         32'hF800_0000);
        single("slt",      4'd8,  32'hFFFF_FFFF, 32'd1,         32'd1);
        single("sltu",     4'd9,  32'hFFFF_FFFF, 32'd1,         32'd0);
        single("slt_rev",  4'd8,  32'd1,         32'hFFFF_FFFF, 32'd0);
        single("op14",     4'd14, 32'd5,         32'd5,         32'd0);
        single("op15",     4'd15, 32'd9,         32'd3,         32'd0);
        ALU_valid_i = 1'b0;
        tick();

        // Multi-cycle multiply and divide.
        multi("mulhu_max", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        multi("mul_max",   4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        multi("mulhu_2_16", 4'd11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        multi("divu",      4'd12, 32'd100, 32'd7, 32'd14);
        multi("remu",      4'd13, 32'd100, 32'd7, 32'd2);
        multi("divu_z",    4'd12, 32'd123, 32'd0, 32'hFFFF_FFFF);
        multi("remu_z",    4'd13, 32'd5,   32'd0, 32'd5);
        tick();

        // Request held during a divide is ignored, then accepted in DONE.
        ALU_valid_i = 1'b1; ALU_op_i = 4'd12; ALU_data1_i = 32'd100; ALU_data2_i = 32'd7;
        tick();
        ALU_op_i = 4'd0; ALU_data1_i = 32'd2; ALU_data2_i = 32'd3;
        pulses = 1;
        while (!ALU_valid_o && pulses < 100) begin
            tick();
            pulses++;
        end
        check("hold_div_lat", pulses, XLEN + 1);
        check("hold_div_res", ALU_result_o, 32'd14);
        tick();
        ALU_valid_i = 1'b0;
        check("done_add_vld", {31'd0, ALU_valid_o}, 32'd1);
        check("done_add_res", ALU_result_o, 32'd5);
        tick();
        check("done_add_once", {31'd0, ALU_valid_o}, 32'd0);

        // Reset in the middle of a multiply.
        ALU_valid_i = 1'b1; ALU_op_i = 4'd10; ALU_data1_i = 32'd3; ALU_data2_i = 32'd5;
        tick();
        ALU_valid_i = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_res", ALU_result_o, 32'd0);
        check("abort_vld", {31'd0, ALU_valid_o}, 32'd0);
        check("abort_busy", {31'd0, ALU_busy_o}, 32'd0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (ALU_valid_o) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        single("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5);
        ALU_valid_i = 1'b0;
        tick();

        // Reset coincident with a request drops it.
        rst_n = 1'b0; ALU_valid_i = 1'b1; ALU_op_i = 4'd0; ALU_data1_i = 32'd1; ALU_data2_i = 32'd1;
        tick();
        rst_n = 1'b1; ALU_valid_i = 1'b0;
        tick();
        check("rst_drop_vld", {31'd0, ALU_valid_o}, 32'd0);
        check("rst_drop_res", ALU_result_o, 32'd0);
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
